// File: rtl/vend_controller.sv
// Vending transaction stage: conditions coin/select/cancel buttons, keeps credit, runs purchase FSM.
// Button events act 2 cycles after first sample; outputs registered; no backpressure, surplus coins returned.
module vend_controller #(
  parameter int MAX_BAL    = 20,
  parameter int HOLD_CYC   = 100,
  parameter int CHANGE_GAP = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nickel,
  input  logic       dime,
  input  logic       sel_strobe,
  input  logic [1:0] cost,
  input  logic [1:0] foodtype,
  input  logic       cancel,
  output logic [4:0] balance,
  output logic [2:0] state,
  output logic       dispense,
  output logic [1:0] dispensed_type,
  output logic       coin_return,
  output logic       change_nickel,
  output logic       change_dime,
  output logic       busy
);

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    MONEY     = 3'd1,
    PURCHASED = 3'd2,
    REJECTION = 3'd3,
    REFUND    = 3'd4
  } state_t;

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int GW = $clog2(CHANGE_GAP + 1);

  // bit order: {cancel, sel, dime, nickel}
  logic [3:0] sync1, sync2, sync3, ev;
  logic       nickel_ev, dime_ev, sel_ev, cancel_ev, coin_ev;
  logic [1:0] coin_val;
  logic [5:0] sum;
  logic       fits;
  logic [4:0] price;

  state_t        st, st_nx;
  logic [4:0]    bal, bal_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [GW-1:0] gap_cnt, gap_nx;
  logic          disp_nx, cr_nx, cn_nx, cd_nx;
  logic [1:0]    dtype_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= {cancel, sel_strobe, dime, nickel};
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign ev        = sync2 & ~sync3;
  assign nickel_ev = ev[0];
  assign dime_ev   = ev[1];
  assign sel_ev    = ev[2];
  assign cancel_ev = ev[3];
  assign coin_val  = {dime_ev, nickel_ev};
  assign coin_ev   = |coin_val;
  assign sum       = {1'b0, bal} + {4'b0, coin_val};
  assign fits      = (sum <= 6'(MAX_BAL));
  assign price     = 5'd5 * ({3'b0, cost} + 5'd1);

  always_comb begin
    st_nx    = st;
    bal_nx   = bal;
    hold_nx  = hold_cnt;
    gap_nx   = gap_cnt;
    disp_nx  = 1'b0;
    cr_nx    = 1'b0;
    cn_nx    = 1'b0;
    cd_nx    = 1'b0;
    dtype_nx = dispensed_type;
    case (st)
      INIT: begin
        if (sel_ev) begin
          st_nx   = REJECTION;
          hold_nx = '0;
          cr_nx   = coin_ev;
        end else if (coin_ev) begin
          if (fits) begin
            bal_nx = sum[4:0];
            st_nx  = MONEY;
          end else begin
            cr_nx = 1'b1;
          end
        end
      end
      MONEY: begin
        if (cancel_ev) begin
          cr_nx  = coin_ev;
          gap_nx = '0;
          st_nx  = (bal == 5'd0) ? INIT : REFUND;
        end else if (sel_ev) begin
          cr_nx   = coin_ev;
          hold_nx = '0;
          if (bal >= price) begin
            bal_nx   = bal - price;
            disp_nx  = 1'b1;
            dtype_nx = foodtype;
            st_nx    = PURCHASED;
          end else begin
            st_nx = REJECTION;
          end
        end else if (coin_ev) begin
          if (fits) bal_nx = sum[4:0];
          else      cr_nx  = 1'b1;
        end
      end
      PURCHASED, REJECTION: begin
        cr_nx = coin_ev;
        if (hold_cnt == HW'(HOLD_CYC - 1)) st_nx = (bal != 5'd0) ? MONEY : INIT;
        else                               hold_nx = hold_cnt + 1'b1;
      end
      REFUND: begin
        cr_nx = coin_ev;
        if (bal == 5'd0) begin
          st_nx = INIT;
        end else if (gap_cnt == '0) begin
          // largest coin first: a dime whenever at least 10c remains
          if (bal >= 5'd2) begin
            cd_nx  = 1'b1;
            bal_nx = bal - 5'd2;
          end else begin
            cn_nx  = 1'b1;
            bal_nx = bal - 5'd1;
          end
          gap_nx = GW'(CHANGE_GAP - 1);
        end else begin
          gap_nx = gap_cnt - 1'b1;
        end
      end
      default: st_nx = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st             <= INIT;
      bal            <= '0;
      hold_cnt       <= '0;
      gap_cnt        <= '0;
      dispense       <= 1'b0;
      dispensed_type <= '0;
      coin_return    <= 1'b0;
      change_nickel  <= 1'b0;
      change_dime    <= 1'b0;
    end else begin
      st             <= st_nx;
      bal            <= bal_nx;
      hold_cnt       <= hold_nx;
      gap_cnt        <= gap_nx;
      dispense       <= disp_nx;
      dispensed_type <= dtype_nx;
      coin_return    <= cr_nx;
      change_nickel  <= cn_nx;
      change_dime    <= cd_nx;
    end
  end

  assign balance = bal;
  assign state   = st;
  assign busy    = (st == PURCHASED) || (st == REJECTION) || (st == REFUND);

endmodule
